// File: rtl/pico_io_port_bank.sv
// I/O port bank and maskable interrupt controller for a pacoblaze3 core.
// Optional periodic tick interrupt source compiled in with PICO_IO_TIMER_EN.
module pico_io_port_bank #(
  parameter int NUM_OUT  = 4,
  parameter int NUM_IN   = 4,
  parameter int NUM_IRQ  = 2,
  parameter int TICK_DIV = 25000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           port_id,
  input  logic [7:0]           out_port,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  output logic [7:0]           in_port,
  output logic                 interrupt,
  input  logic                 interrupt_ack,
  output logic [NUM_OUT*8-1:0] out_data,
  output logic [NUM_OUT-1:0]   out_wr,
  input  logic [NUM_IN*8-1:0]  in_data,
  output logic [NUM_IN-1:0]    in_rd,
  input  logic [NUM_IRQ-1:0]   irq_src
);

  localparam logic [7:0] ADDR_MASK  = 8'hF0;
  localparam logic [7:0] ADDR_PEND  = 8'hF1;
  localparam logic [7:0] ADDR_CLEAR = 8'hF2;
  localparam logic [7:0] ADDR_RAW   = 8'hF3;

  localparam logic [7:0] SRC_BITS =
    8'((9'd1 << NUM_IRQ) - 9'd1);
`ifdef PICO_IO_TIMER_EN
  localparam logic [7:0] TMR_BIT = 8'(9'd1 << NUM_IRQ);
`else
  localparam logic [7:0] TMR_BIT = 8'h00;
`endif
  localparam logic [7:0] PEND_BITS = SRC_BITS | TMR_BIT;

  if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_out
    $error("NUM_OUT must be 1..16");
  end
  if (NUM_IN < 1 || NUM_IN > 16) begin : g_bad_in
    $error("NUM_IN must be 1..16");
  end
  if (NUM_IRQ < 1 || NUM_IRQ > 7) begin : g_bad_irq
    $error("NUM_IRQ must be 1..7");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end

  logic [NUM_OUT*8-1:0] out_q, out_d;
  logic [NUM_OUT-1:0]   out_wr_q, out_wr_d;
  logic [NUM_IN-1:0]    in_rd_q, in_rd_d;
  logic [7:0]           in_port_q, in_port_d;
  logic [7:0]           mask_q, mask_d;
  logic [7:0]           pend_q, pend_d;
  logic [NUM_IRQ-1:0]   irq_prev_q, irq_prev_d;
  logic                 int_q, int_d;
  logic                 tick;

`ifdef PICO_IO_TIMER_EN
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign tick = 1'b0;
`endif

  logic                 in_hit;
  logic                 out_hit;
  logic [7:0]           in_val;
  logic [7:0]           out_val;
  logic [7:0]           raw_v;
  logic [7:0]           set_v;
  logic [7:0]           clr_v;
  logic [NUM_IRQ-1:0]   rise;

  always_comb begin
    in_hit   = 1'b0;
    in_val   = 8'h00;
    in_rd_d  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (port_id == 8'(k)) begin
        in_hit     = 1'b1;
        in_val     = in_data[8*k +: 8];
        in_rd_d[k] = read_strobe;
      end
    end
  end

  always_comb begin
    out_hit  = 1'b0;
    out_val  = 8'h00;
    out_d    = out_q;
    out_wr_d = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (port_id == 8'(128 + k)) begin
        out_hit = 1'b1;
        out_val = out_q[8*k +: 8];
        if (write_strobe) begin
          out_d[8*k +: 8] = out_port;
          out_wr_d[k]     = 1'b1;
        end
      end
    end
  end

  // New edges are OR-ed in after the clear, so a same-cycle set wins.
  always_comb begin
    rise  = irq_src & ~irq_prev_q;
    raw_v = 8'h00;
    raw_v[NUM_IRQ-1:0] = irq_src;
    set_v = 8'h00;
    set_v[NUM_IRQ-1:0] = rise;
    set_v = set_v | (TMR_BIT & {8{tick}});
    clr_v = (write_strobe && port_id == ADDR_CLEAR)
          ? out_port : 8'h00;
    pend_d = ((pend_q & ~clr_v) | set_v) & PEND_BITS;
    mask_d = (write_strobe && port_id == ADDR_MASK)
           ? out_port : mask_q;
    irq_prev_d = irq_src;
    int_d = (|(pend_q & mask_q)) & ~interrupt_ack;
  end

  always_comb begin
    in_port_d = 8'h00;
    unique case (1'b1)
      in_hit:                  in_port_d = in_val;
      out_hit:                 in_port_d = out_val;
      (port_id == ADDR_MASK):  in_port_d = mask_q;
      (port_id == ADDR_PEND):  in_port_d = pend_q;
      (port_id == ADDR_RAW):   in_port_d = raw_v;
      default:                 in_port_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= '0;
      out_wr_q   <= '0;
      in_rd_q    <= '0;
      in_port_q  <= 8'h00;
      mask_q     <= 8'h00;
      pend_q     <= 8'h00;
      irq_prev_q <= '0;
      int_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_wr_q   <= out_wr_d;
      in_rd_q    <= in_rd_d;
      in_port_q  <= in_port_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      irq_prev_q <= irq_prev_d;
      int_q      <= int_d;
    end
  end

  assign out_data  = out_q;
  assign out_wr    = out_wr_q;
  assign in_rd     = in_rd_q;
  assign in_port   = in_port_q;
  assign interrupt = int_q;

endmodule
